// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding controller: select codes,
// destination-register shadow entry and the "stage writes register" test.
package fwd_sel_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_RET = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 is_load;
  } shadow_t;

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  function automatic logic entry_writes(input shadow_t e, input logic [REG_IDX_W-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_match.sv
// Per-operand forwarding priority encoder: youngest in-flight producer wins.
module fwd_match
  import fwd_sel_ctrl_pkg::*;
#(
  parameter bit WT_REGFILE = 1'b0
) (
  input  logic [REG_IDX_W-1:0] i_rs,
  input  logic                 i_use,
  input  shadow_t              i_ex,
  input  shadow_t              i_mem,
  input  shadow_t              i_wb,
  output logic [1:0]           o_sel
);

  // Stage names are those the consumer sees now; each producer is one stage
  // further along by the time the consumer occupies EX.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use && (i_rs != '0)) begin
      if (entry_writes(i_ex, i_rs)) begin
        o_sel = FWD_MEM;
      end else if (entry_writes(i_mem, i_rs)) begin
        o_sel = FWD_WB;
      end else if (!WT_REGFILE && entry_writes(i_wb, i_rs)) begin
        o_sel = FWD_RET;
      end
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Forwarding/hazard controller beside the ID/EX register of the 5-stage RV32I
// pipeline: shadows rd metadata EX..RET, registers operand selects, flags load-use.
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int XLEN_REGS  = 32,
  parameter bit WT_REGFILE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_is_load,
  input  logic                         flush,
  output logic                         stall,
  output logic [1:0]                   fwd_a_sel,
  output logic [1:0]                   fwd_b_sel,
  output logic                         ex_valid,
  output logic                         mem_valid,
  output logic                         wb_valid
);

  shadow_t    r_ex, r_mem, r_wb, r_ret;
  logic [1:0] r_a_sel, r_b_sel;
  shadow_t    w_id;
  logic       w_stall, w_accept;
  logic [1:0] w_a_sel, w_b_sel;

  assign w_id = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

  // A load still in EX has no data yet; its consumer must wait one cycle.
  assign w_stall  = id_valid && !flush && r_ex.is_load &&
                    ((id_use_rs1 && entry_writes(r_ex, id_rs1)) ||
                     (id_use_rs2 && entry_writes(r_ex, id_rs2)));
  assign w_accept = id_valid && !flush && !w_stall;

  fwd_match #(.WT_REGFILE(WT_REGFILE)) u_match_a (
    .i_rs  (id_rs1),
    .i_use (id_use_rs1),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_a_sel)
  );

  fwd_match #(.WT_REGFILE(WT_REGFILE)) u_match_b (
    .i_rs  (id_rs2),
    .i_use (id_use_rs2),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_b_sel)
  );

  // ID -> EX boundary and unconditional shadow shift EX -> MEM -> WB -> RET
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_ret   <= '0;
      r_a_sel <= FWD_RF;
      r_b_sel <= FWD_RF;
    end else begin
      r_ret   <= r_wb;
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_accept ? w_id : '0;
      r_a_sel <= w_accept ? w_a_sel : FWD_RF;
      r_b_sel <= w_accept ? w_b_sel : FWD_RF;
    end
  end

  assign stall     = w_stall;
  assign fwd_a_sel = r_a_sel;
  assign fwd_b_sel = r_b_sel;
  assign ex_valid  = r_ex.valid;
  assign mem_valid = r_mem.valid;
  assign wb_valid  = r_wb.valid;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Bench for fwd_sel_ctrl: directed vector table, reset/flush corner sequences and
// random instruction streams checked against a producer-distance model.
module tb_fwd_sel_ctrl;

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, fl;
    logic       st;
    logic [1:0] a, b, a1, b1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;

  logic       stall0, stall1, exv0, exv1, memv0, memv1, wbv0, wbv1;
  logic [1:0] a0, b0, a1, b1;

  int n_vec = 0;
  int n_err = 0;

  // Model: the last three instruction slots issued into EX (0 = EX, 1 = MEM, 2 = WB).
  logic       m_vld[3];
  logic [4:0] m_rd[3];
  logic       m_rw[3];
  logic       m_ld[3];

  vec_t tbl[18];

  always #5 clk = ~clk;

  fwd_sel_ctrl #(.XLEN_REGS(32), .WT_REGFILE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall0), .fwd_a_sel(a0), .fwd_b_sel(b0),
    .ex_valid(exv0), .mem_valid(memv0), .wb_valid(wbv0)
  );

  fwd_sel_ctrl #(.XLEN_REGS(32), .WT_REGFILE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall1), .fwd_a_sel(a1), .fwd_b_sel(b1),
    .ex_valid(exv1), .mem_valid(memv1), .wb_valid(wbv1)
  );

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic fl, input logic st,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic [1:0] ea1, input logic [1:0] eb1);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.ld = ld; v.fl = fl; v.st = st; v.a = ea; v.b = eb; v.a1 = ea1; v.b1 = eb1;
    return v;
  endfunction

  function automatic logic m_wr(input int k, input logic [4:0] r);
    return m_vld[k] && m_rw[k] && (m_rd[k] == r) && (r != 5'd0);
  endfunction

  // Code = distance to the nearest older producer (1 -> MEM, 2 -> WB, 3 -> RET).
  function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic u, input bit wt);
    if (!u || rs == 5'd0) return 2'd0;
    for (int d = 0; d < 3; d++) begin
      if (m_wr(d, rs)) return (d == 2 && wt) ? 2'd0 : 2'(d + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic m_stall(input vec_t v);
    return v.vld && !v.fl && m_ld[0] &&
           ((v.u1 && m_wr(0, v.rs1)) || (v.u2 && m_wr(0, v.rs2)));
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 1'b0; m_rd[k] = '0; m_rw[k] = 1'b0; m_ld[k] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    id_rd = v.rd; id_reg_write = v.rw; id_is_load = v.ld; flush = v.fl;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic step(input vec_t v, input bit use_tbl, output logic st);
    logic       acc;
    logic [1:0] ea0, eb0, ea1, eb1;
    @(negedge clk);
    drive(v);
    #1;
    st = m_stall(v);
    chk("stall", {1'b0, stall0}, {1'b0, st});
    chk("stall_wt1", {1'b0, stall1}, {1'b0, st});
    if (use_tbl) chk("stall_tbl", {1'b0, stall0}, {1'b0, v.st});
    acc = v.vld && !v.fl && !st;
    ea0 = acc ? m_sel(v.rs1, v.u1, 1'b0) : 2'd0;
    eb0 = acc ? m_sel(v.rs2, v.u2, 1'b0) : 2'd0;
    ea1 = acc ? m_sel(v.rs1, v.u1, 1'b1) : 2'd0;
    eb1 = acc ? m_sel(v.rs2, v.u2, 1'b1) : 2'd0;
    @(posedge clk);
    for (int k = 2; k > 0; k--) begin
      m_vld[k] = m_vld[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_vld[0] = acc; m_rd[0] = v.rd; m_rw[0] = v.rw; m_ld[0] = v.ld;
    #1;
    chk("sel_a", a0, ea0);
    chk("sel_b", b0, eb0);
    chk("sel_a_wt1", a1, ea1);
    chk("sel_b_wt1", b1, eb1);
    if (use_tbl) begin
      chk("sel_a_tbl", a0, v.a);
      chk("sel_b_tbl", b0, v.b);
      chk("sel_a_wt1_tbl", a1, v.a1);
      chk("sel_b_wt1_tbl", b1, v.b1);
    end
    chk("ex_valid", {1'b0, exv0}, {1'b0, m_vld[0]});
    chk("mem_valid", {1'b0, memv0}, {1'b0, m_vld[1]});
    chk("wb_valid", {1'b0, wbv0}, {1'b0, m_vld[2]});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"}, {stall1, stall0}, 2'b00);
    chk({nm, "_sel_a"}, a0 | a1, 2'b00);
    chk({nm, "_sel_b"}, b0 | b1, 2'b00);
    chk({nm, "_valid"}, {exv0 | memv0 | wbv0, exv1 | memv1 | wbv1}, 2'b00);
  endtask

  initial begin
    logic st;
    vec_t cur;

    //            vld rs1 rs2 u1 u2 rd rw ld fl  st  a  b a1 b1
    tbl[0]  = mk(1,  1,  2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 0); // add x5
    tbl[1]  = mk(1,  5,  5, 1, 1,  6, 1, 0, 0,  0, 1, 1, 1, 1); // add x6,x5,x5
    tbl[2]  = mk(0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
    tbl[3]  = mk(1,  5,  5, 1, 1,  0, 0, 0, 0,  0, 3, 3, 0, 0); // x5 at distance 3
    tbl[4]  = mk(1,  0,  0, 0, 0,  7, 1, 0, 0,  0, 0, 0, 0, 0); // writer x7
    tbl[5]  = mk(0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
    tbl[6]  = mk(1,  7,  0, 1, 0,  0, 0, 0, 0,  0, 2, 0, 2, 0); // x7 at distance 2
    tbl[7]  = mk(1,  1,  0, 1, 0,  8, 1, 1, 0,  0, 0, 0, 0, 0); // lw x8
    tbl[8]  = mk(1,  8,  1, 1, 1,  9, 1, 0, 0,  1, 0, 0, 0, 0); // add x9,x8,x1 stalls
    tbl[9]  = mk(1,  8,  1, 1, 1,  9, 1, 0, 0,  0, 2, 0, 2, 0); // replay after stall
    tbl[10] = mk(1,  3,  4, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0, 0); // writes x0
    tbl[11] = mk(1,  0,  0, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0); // reads x0
    tbl[12] = mk(1,  0,  0, 0, 0, 10, 1, 0, 0,  0, 0, 0, 0, 0); // writer x10
    tbl[13] = mk(1, 10,  0, 1, 0, 10, 1, 0, 0,  0, 1, 0, 1, 0); // writer x10 reads x10
    tbl[14] = mk(1, 10, 10, 1, 1, 11, 1, 0, 0,  0, 1, 1, 1, 1); // distance 1 beats 2
    tbl[15] = mk(1,  0,  0, 0, 0,  8, 1, 1, 0,  0, 0, 0, 0, 0); // lw x8
    tbl[16] = mk(1,  8,  8, 1, 1, 12, 1, 0, 1,  0, 0, 0, 0, 0); // hazard + flush
    tbl[17] = mk(1,  8,  0, 1, 0, 13, 1, 0, 0,  0, 2, 0, 2, 0); // load now in MEM

    m_clear();
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) step(tbl[i], 1'b1, st);

    // Asynchronous reset with a live load-use hazard on x5.
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, st);
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, st);
    @(negedge clk);
    drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_stall", {stall1, stall0}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    m_clear();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    step(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, st);

    st = 1'b0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        cur.vld = ($urandom_range(0, 7) != 0);
        cur.rs1 = 5'($urandom_range(0, 7));
        cur.rs2 = 5'($urandom_range(0, 7));
        cur.u1  = 1'($urandom_range(0, 1));
        cur.u2  = 1'($urandom_range(0, 1));
        cur.rd  = 5'($urandom_range(0, 7));
        cur.rw  = ($urandom_range(0, 3) != 0);
        cur.ld  = ($urandom_range(0, 2) == 0);
      end
      cur.fl = ($urandom_range(0, 9) == 0);
      step(cur, 1'b0, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
